// File: rtl/racing_pkg.sv
// Shared definitions for the PS/2 keyboard path: scan-code constants
// and the frame receiver state encoding.
package racing_pkg;

    localparam logic [7:0] SC_EXT         = 8'hE0;
    localparam logic [7:0] SC_BRK         = 8'hF0;
    localparam logic [7:0] SC_LEFT_ARROW  = 8'h6B;
    localparam logic [7:0] SC_RIGHT_ARROW = 8'h74;
    localparam logic [7:0] SC_A           = 8'h1C;
    localparam logic [7:0] SC_D           = 8'h23;
    localparam logic [7:0] SC_P           = 8'h4D;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    // PS/2 frames carry odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the keyboard lines, deframes one byte
// per 11-bit frame and flags malformed or stalled frames.
module ps2_rx
    import racing_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [1:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             clk_prev_q;
    rx_state_e        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    logic fall;
    logic din;
    logic timeout;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its input from the same clock edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_sync_q  <= 2'b00;
            data_sync_q <= 2'b00;
            clk_prev_q  <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign fall    = clk_prev_q & ~clk_sync_q[1];
    assign din     = data_sync_q[1];
    assign timeout = (state_q != RX_IDLE) && (tmo_cnt_q == TMO_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= RX_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            parity_q  <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (state_q == RX_IDLE || fall || timeout) begin
            tmo_cnt_d = '0;
        end

        if (timeout) begin
            state_d = RX_IDLE;
        end else if (fall) begin
            unique case (state_q)
                RX_IDLE: begin
                    if (!din) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                RX_DATA: begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    parity_d = din;
                    state_d  = RX_STOP;
                end
                RX_STOP: state_d = RX_IDLE;
                default: state_d = RX_IDLE;
            endcase
        end
    end

    // Completion and error strobes are combinational on the stop-bit edge so
    // the decoder registers them one cycle later.
    always_comb begin
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        if (timeout) begin
            frame_err_o = 1'b1;
        end else if (fall) begin
            if (state_q == RX_IDLE) begin
                frame_err_o = din;
            end else if (state_q == RX_STOP) begin
                byte_valid_o = din && odd_parity_ok(shift_q, parity_q);
                frame_err_o  = !(din && odd_parity_ok(shift_q, parity_q));
            end
        end
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns received PS/2 scan codes into held-key levels for steering
// (Left-arrow/A, Right-arrow/D) and a pause toggle on P.
module ps2_key_decoder
    import racing_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       left_key,
    output logic       right_key,
    output logic       pause,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_i   (ps2_clk),
        .ps2_data_i  (ps2_data),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .frame_err_o (rx_err)
    );

    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic       left_arrow_q, left_arrow_d;
    logic       left_a_q, left_a_d;
    logic       right_arrow_q, right_arrow_d;
    logic       right_d_q, right_d_d;
    logic       p_held_q, p_held_d;
    logic       pause_q, pause_d;
    logic [7:0] scan_code_q, scan_code_d;
    logic       code_valid_q, code_valid_d;
    logic       frame_err_q, frame_err_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            left_arrow_q  <= 1'b0;
            left_a_q      <= 1'b0;
            right_arrow_q <= 1'b0;
            right_d_q     <= 1'b0;
            p_held_q      <= 1'b0;
            pause_q       <= 1'b0;
            scan_code_q   <= 8'h00;
            code_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            left_arrow_q  <= left_arrow_d;
            left_a_q      <= left_a_d;
            right_arrow_q <= right_arrow_d;
            right_d_q     <= right_d_d;
            p_held_q      <= p_held_d;
            pause_q       <= pause_d;
            scan_code_q   <= scan_code_d;
            code_valid_q  <= code_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    always_comb begin
        ext_d         = ext_q;
        brk_d         = brk_q;
        left_arrow_d  = left_arrow_q;
        left_a_d      = left_a_q;
        right_arrow_d = right_arrow_q;
        right_d_d     = right_d_q;
        p_held_d      = p_held_q;
        pause_d       = pause_q;
        scan_code_d   = scan_code_q;
        code_valid_d  = rx_valid;
        frame_err_d   = rx_err;

        if (rx_valid) begin
            scan_code_d = rx_byte;
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (ext_q && rx_byte == SC_LEFT_ARROW)  left_arrow_d  = !brk_q;
                if (!ext_q && rx_byte == SC_A)          left_a_d      = !brk_q;
                if (ext_q && rx_byte == SC_RIGHT_ARROW) right_arrow_d = !brk_q;
                if (!ext_q && rx_byte == SC_D)          right_d_d     = !brk_q;
                // Typematic repeats of P arrive as makes while p_held is set.
                if (!ext_q && rx_byte == SC_P) begin
                    if (brk_q) begin
                        p_held_d = 1'b0;
                    end else if (!p_held_q) begin
                        pause_d  = !pause_q;
                        p_held_d = 1'b1;
                    end
                end
            end
        end else if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end

    assign left_key   = left_arrow_q | left_a_q;
    assign right_key  = right_arrow_q | right_d_q;
    assign pause      = pause_q;
    assign scan_code  = scan_code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;

endmodule
